writeback_stage: RTL and testbench
==================================

WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 16: datapath width; a multiple of 8 and at least 16.
REQ-002 SHALL have parameter REG_ADDR_W, default 4: register-index width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port valid_m, input, 1 bit: the M stage presents a valid instruction.
REQ-006 SHALL have port stall_w, input, 1 bit: hold the W register contents.
REQ-007 SHALL have port flush_w, input, 1 bit: squash the instruction entering W.
REQ-008 SHALL have port ResultSrcM, input, 2 bits: result source; 00 ALU, 01 load data, 10 PC+4, 11 immediate.
REQ-009 SHALL have port LoadTypeM, input, 2 bits: load format; 00 full word, 01 signed byte, 10 unsigned byte, 11 full word.
REQ-010 SHALL have port RegWriteM, input, 1 bit: the instruction writes the register file.
REQ-011 SHALL have port RdM, input, REG_ADDR_W bits: destination register index.
REQ-012 SHALL have ports ALU_ResultM, ReadDataM, PCPlus4M and ImmExtM, each input, DATA_W bits: the candidate results.
REQ-013 SHALL have port ResultW, output, DATA_W bits: the writeback value.
REQ-014 SHALL have port RdW, output, REG_ADDR_W bits: the registered destination index.
REQ-015 SHALL have port RegWriteW, output, 1 bit: the qualified register-file write enable.
REQ-016 SHALL have port valid_w, output, 1 bit: the W register holds a live instruction.
REQ-017 SHALL have port retire_cnt, output, 32 bits: the retired-instruction count.

Function
REQ-018 SHALL capture valid_m, ResultSrcM, LoadTypeM, RegWriteM, RdM, the four data inputs and byte-offset bits ALU_ResultM[log2(DATA_W/8)-1:0] into the W register; latency is 1 cycle.
REQ-019 SHALL apply register-update priority per edge: rst, then flush_w, then stall_w, then load.
REQ-020 SHALL on flush_w clear valid_w to 0 and leave the other fields don't-care; flush_w overrides a simultaneous stall_w.
REQ-021 SHALL on stall_w (without flush_w) hold every W field unchanged.
REQ-022 SHALL otherwise load all fields, with valid_w taking the value of valid_m.
REQ-023 SHALL derive ResultW combinationally from the registered fields only, selected by registered ResultSrc.
REQ-024 SHALL, for the load source, select the byte lane of registered ReadData using the registered byte offset (lane 0 = bits 7:0).
REQ-025 SHALL sign-extend that byte to DATA_W bits for LoadType 01 and zero-extend it for LoadType 10.
REQ-026 SHALL pass the load word through unchanged for LoadType 00 and 11.
REQ-027 SHALL ignore LoadType for the ALU, PC+4 and immediate sources.
REQ-028 SHALL drive RegWriteW = valid_w AND registered RegWrite AND (RdW != 0); writes to register 0 are suppressed.
REQ-029 SHALL drive RegWriteW to 0 while valid_w = 0, whatever the other fields hold.
REQ-030 SHALL assert RegWriteW on every cycle of a stall, since the held instruction remains live; the register file write is idempotent.

Reset
REQ-031 SHALL on rst at a rising edge force valid_w = 0, RdW = 0, all registered data and control to 0, and retire_cnt = 0.
REQ-032 SHALL therefore present ResultW = 0 and RegWriteW = 0 in the cycle after reset.
REQ-033 SHALL let rst asserted mid-stall or mid-flush override both.
REQ-034 SHALL discard the in-flight instruction on reset without counting it.

Configuration
REQ-035 SHALL use the macro WB_RETIRE_CNT_EN.
REQ-036 SHALL, when WB_RETIRE_CNT_EN is defined, increment retire_cnt by 1 on each edge where a valid instruction is loaded: not rst, not flush_w, not stall_w, valid_m = 1.
REQ-037 SHALL wrap retire_cnt from 0xFFFFFFFF to 0.
REQ-038 SHALL, when WB_RETIRE_CNT_EN is not defined, keep the retire_cnt port present but tied to constant 0, and infer no counter flops.

Verification
REQ-039 SHALL cover source select: DATA_W=16; ALU=0x1234, ReadData=0xABCD, PC+4=0x0042, Imm=0xFFF0, ResultSrc swept 00..11 -> ResultW 0x1234, 0xABCD, 0x0042, 0xFFF0 one cycle later.
REQ-040 SHALL cover byte loads: ReadData=0x80F7, ResultSrc=01, offset 1 -> LoadType 01 gives 0xFF80, LoadType 10 gives 0x0080; offset 0 with LoadType 01 -> 0xFFF7.
REQ-041 SHALL cover register 0: RegWriteM=1, RdM=0, valid_m=1 -> RegWriteW=0; with RdM=5 -> RegWriteW=1 and RdW=5.
REQ-042 SHALL cover stall then flush: load Rd=3 and value 0x0011, then stall_w for 3 cycles with new inputs -> outputs hold Rd=3/0x0011 and RegWriteW stays 1; then stall_w and flush_w together -> valid_w=0 and RegWriteW=0.
REQ-043 SHALL cover reset mid-operation: rst on a valid stalled instruction -> next cycle valid_w=0, ResultW=0, RdW=0, retire_cnt=0.
REQ-044 SHALL cover the counter: with WB_RETIRE_CNT_EN defined and the count preloaded to 0xFFFFFFFE, two valid loads -> 0xFFFFFFFF, then 0; stalled or flushed cycles leave the count unchanged; without the macro retire_cnt stays 0.

Source files
------------

// File: rtl/writeback_stage.sv
// writeback_stage: W pipeline register plus result selection and load formatting.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN;
// without it retire_cnt is tied to zero and no counter flops exist.
module writeback_stage #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_m,
    input  logic                  stall_w,
    input  logic                  flush_w,
    input  logic [1:0]            ResultSrcM,
    input  logic [1:0]            LoadTypeM,
    input  logic                  RegWriteM,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic [DATA_W-1:0]     ALU_ResultM,
    input  logic [DATA_W-1:0]     ReadDataM,
    input  logic [DATA_W-1:0]     PCPlus4M,
    input  logic [DATA_W-1:0]     ImmExtM,
    output logic [DATA_W-1:0]     ResultW,
    output logic [REG_ADDR_W-1:0] RdW,
    output logic                  RegWriteW,
    output logic                  valid_w,
    output logic [31:0]           retire_cnt
);

    localparam int NLANES = DATA_W / 8;
    localparam int OFF_W  = (NLANES > 1) ? $clog2(NLANES) : 1;

    typedef enum logic [1:0] {SRC_ALU, SRC_LOAD, SRC_PC4, SRC_IMM} src_e;
    typedef enum logic [1:0] {LD_WORD, LD_SB, LD_UB, LD_WORD_ALT} ltype_e;

    logic                  valid_q,    valid_d;
    src_e                  src_q,      src_d;
    ltype_e                ltype_q,    ltype_d;
    logic                  regwrite_q, regwrite_d;
    logic [REG_ADDR_W-1:0] rd_q,       rd_d;
    logic [DATA_W-1:0]     alu_q,      alu_d;
    logic [DATA_W-1:0]     rdata_q,    rdata_d;
    logic [DATA_W-1:0]     pc4_q,      pc4_d;
    logic [DATA_W-1:0]     imm_q,      imm_d;
    logic [OFF_W-1:0]      off_q,      off_d;

    logic [7:0]            byte_lane;
    logic [DATA_W-1:0]     load_val;

    // Next-state of the W register: flush squashes, stall holds, otherwise load.
    always_comb begin
        valid_d    = valid_q;
        src_d      = src_q;
        ltype_d    = ltype_q;
        regwrite_d = regwrite_q;
        rd_d       = rd_q;
        alu_d      = alu_q;
        rdata_d    = rdata_q;
        pc4_d      = pc4_q;
        imm_d      = imm_q;
        off_d      = off_q;
        if (flush_w) begin
            valid_d = 1'b0;
        end else if (!stall_w) begin
            valid_d    = valid_m;
            src_d      = src_e'(ResultSrcM);
            ltype_d    = ltype_e'(LoadTypeM);
            regwrite_d = RegWriteM;
            rd_d       = RdM;
            alu_d      = ALU_ResultM;
            rdata_d    = ReadDataM;
            pc4_d      = PCPlus4M;
            imm_d      = ImmExtM;
            off_d      = ALU_ResultM[OFF_W-1:0];
        end
    end

    // W register with synchronous reset clearing every field.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            src_q      <= SRC_ALU;
            ltype_q    <= LD_WORD;
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            alu_q      <= '0;
            rdata_q    <= '0;
            pc4_q      <= '0;
            imm_q      <= '0;
            off_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            src_q      <= src_d;
            ltype_q    <= ltype_d;
            regwrite_q <= regwrite_d;
            rd_q       <= rd_d;
            alu_q      <= alu_d;
            rdata_q    <= rdata_d;
            pc4_q      <= pc4_d;
            imm_q      <= imm_d;
            off_q      <= off_d;
        end
    end

    // Byte-lane extraction and sign/zero extension of the registered load word.
    always_comb begin
        byte_lane = '0;
        for (int unsigned i = 0; i < NLANES; i++) begin
            if (off_q == OFF_W'(i)) byte_lane = rdata_q[i*8 +: 8];
        end
        case (ltype_q)
            LD_SB:   load_val = {{(DATA_W-8){byte_lane[7]}}, byte_lane};
            LD_UB:   load_val = {{(DATA_W-8){1'b0}}, byte_lane};
            default: load_val = rdata_q;
        endcase
    end

    // Writeback value selected purely from registered fields.
    always_comb begin
        case (src_q)
            SRC_ALU:  ResultW = alu_q;
            SRC_LOAD: ResultW = load_val;
            SRC_PC4:  ResultW = pc4_q;
            SRC_IMM:  ResultW = imm_q;
            default:  ResultW = alu_q;
        endcase
    end

    assign RdW       = rd_q;
    assign valid_w   = valid_q;
    assign RegWriteW = valid_q & regwrite_q & (rd_q != '0);

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt_q, retire_cnt_d;

    // Count each valid instruction accepted into W; wraps naturally at 2^32.
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (valid_m && !flush_w && !stall_w) retire_cnt_d = retire_cnt_q + 32'd1;
    end

    // Retire counter register, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) retire_cnt_q <= '0;
        else     retire_cnt_q <= retire_cnt_d;
    end

    assign retire_cnt = retire_cnt_q;
`else
    assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage (DATA_W=16) with an expected-result queue.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst, valid_m, stall_w, flush_w, RegWriteM;
    logic [1:0]  ResultSrcM, LoadTypeM;
    logic [3:0]  RdM;
    logic [15:0] ALU_ResultM, ReadDataM, PCPlus4M, ImmExtM;
    logic [15:0] ResultW;
    logic [3:0]  RdW;
    logic        RegWriteW, valid_w;
    logic [31:0] retire_cnt;

    writeback_stage #(.DATA_W(16), .REG_ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .valid_m(valid_m), .stall_w(stall_w), .flush_w(flush_w),
        .ResultSrcM(ResultSrcM), .LoadTypeM(LoadTypeM), .RegWriteM(RegWriteM), .RdM(RdM),
        .ALU_ResultM(ALU_ResultM), .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M), .ImmExtM(ImmExtM),
        .ResultW(ResultW), .RdW(RdW), .RegWriteW(RegWriteW), .valid_w(valid_w),
        .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

`ifdef WB_RETIRE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        logic [15:0] res;
        logic [3:0]  rd;
        logic        rw;
        logic        v;
        logic        chk_data;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    exp_t        last_exp;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_cnt = '0;

    function automatic logic [15:0] model(input logic [1:0] src, input logic [1:0] lt,
                                          input logic [15:0] alu, input logic [15:0] rdata,
                                          input logic [15:0] pc, input logic [15:0] imm);
        logic [7:0] b;
        b = alu[0] ? rdata[15:8] : rdata[7:0];
        case (src)
            2'b00: return alu;
            2'b01: begin
                if (lt == 2'b01)      return {{8{b[7]}}, b};
                else if (lt == 2'b10) return {8'h00, b};
                else                  return rdata;
            end
            2'b10: return pc;
            default: return imm;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic drive_load(input string tag, input logic vm, input logic [1:0] src,
                              input logic [1:0] lt, input logic rw, input logic [3:0] rd,
                              input logic [15:0] alu, input logic [15:0] rdata,
                              input logic [15:0] pc, input logic [15:0] imm);
        exp_t e;
        rst = 1'b0; stall_w = 1'b0; flush_w = 1'b0;
        valid_m = vm; ResultSrcM = src; LoadTypeM = lt; RegWriteM = rw; RdM = rd;
        ALU_ResultM = alu; ReadDataM = rdata; PCPlus4M = pc; ImmExtM = imm;
        e.res = model(src, lt, alu, rdata, pc, imm);
        e.rd = rd;
        e.v = vm;
        e.rw = vm & rw & (rd != 4'd0);
        e.chk_data = 1'b1;
        e.tag = tag;
        sb.push_back(e);
        last_exp = e;
    endtask

    // Stall with fresh inputs presented: the previous instruction must hold.
    task automatic drive_stall(input string tag, input logic [15:0] junk);
        exp_t e;
        stall_w = 1'b1; flush_w = 1'b0; rst = 1'b0;
        valid_m = 1'b1; ResultSrcM = junk[1:0]; LoadTypeM = junk[3:2]; RegWriteM = 1'b1;
        RdM = junk[7:4]; ALU_ResultM = junk; ReadDataM = ~junk; PCPlus4M = junk ^ 16'h5A5A;
        ImmExtM = junk + 16'd7;
        e = last_exp;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic tick_check();
        exp_t e;
        if (rst) exp_cnt = '0;
        else if (CNT_EN && valid_m && !flush_w && !stall_w) exp_cnt = exp_cnt + 32'd1;
        @(posedge clk);
        #1;
        chk("sb_depth", sb.size(), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({e.tag, "_valid"}, valid_w, e.v);
            chk({e.tag, "_regwr"}, RegWriteW, e.rw);
            if (e.chk_data) begin
                chk({e.tag, "_result"}, ResultW, e.res);
                chk({e.tag, "_rd"}, RdW, e.rd);
            end
            chk({e.tag, "_cnt"}, retire_cnt, exp_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        // reset
        drive_load("reset", 1'b1, 2'b11, 2'b00, 1'b1, 4'd9, 16'h1, 16'h2, 16'h3, 16'h4);
        rst = 1'b1;
        sb.delete();
        e.res = '0; e.rd = '0; e.rw = 1'b0; e.v = 1'b0; e.chk_data = 1'b1; e.tag = "reset";
        sb.push_back(e);
        tick_check();

        // idle cycle, preloading the counter near its wrap point when present
        drive_load("idle", 1'b0, 2'b00, 2'b00, 1'b0, 4'd0, 16'h0, 16'h0, 16'h0, 16'h0);
`ifdef WB_RETIRE_CNT_EN
        force dut.retire_cnt_q = 32'hFFFF_FFFE;
        exp_cnt = 32'hFFFF_FFFE;
`endif
        tick_check();
`ifdef WB_RETIRE_CNT_EN
        release dut.retire_cnt_q;
`endif

        // source select sweep (counter reaches 0xFFFFFFFF, then wraps to 0)
        drive_load("src_alu",  1'b1, 2'b00, 2'b00, 1'b1, 4'd1, 16'h1234, 16'hABCD, 16'h0042, 16'hFFF0);
        tick_check();
        drive_load("src_load", 1'b1, 2'b01, 2'b00, 1'b1, 4'd1, 16'h1234, 16'hABCD, 16'h0042, 16'hFFF0);
        tick_check();
        drive_load("src_pc4",  1'b1, 2'b10, 2'b00, 1'b1, 4'd1, 16'h1234, 16'hABCD, 16'h0042, 16'hFFF0);
        tick_check();
        drive_load("src_imm",  1'b1, 2'b11, 2'b00, 1'b1, 4'd1, 16'h1234, 16'hABCD, 16'h0042, 16'hFFF0);
        tick_check();
        drive_load("alu_lt01", 1'b1, 2'b00, 2'b01, 1'b1, 4'd2, 16'h1235, 16'hABCD, 16'h0042, 16'hFFF0);
        tick_check();
        drive_load("imm_lt10", 1'b1, 2'b11, 2'b10, 1'b1, 4'd2, 16'h1235, 16'hABCD, 16'h0042, 16'h8001);
        tick_check();

        // byte loads
        drive_load("lb_off1",  1'b1, 2'b01, 2'b01, 1'b1, 4'd4, 16'h0001, 16'h80F7, 16'h0, 16'h0);
        tick_check();
        drive_load("lbu_off1", 1'b1, 2'b01, 2'b10, 1'b1, 4'd4, 16'h0001, 16'h80F7, 16'h0, 16'h0);
        tick_check();
        drive_load("lb_off0",  1'b1, 2'b01, 2'b01, 1'b1, 4'd4, 16'h0000, 16'h80F7, 16'h0, 16'h0);
        tick_check();
        drive_load("lbu_off0", 1'b1, 2'b01, 2'b10, 1'b1, 4'd4, 16'h0000, 16'h80F7, 16'h0, 16'h0);
        tick_check();
        drive_load("lw_lt11",  1'b1, 2'b01, 2'b11, 1'b1, 4'd4, 16'h0001, 16'h80F7, 16'h0, 16'h0);
        tick_check();

        // register 0 suppression and invalid instruction
        drive_load("rd0",      1'b1, 2'b00, 2'b00, 1'b1, 4'd0, 16'h7777, 16'h0, 16'h0, 16'h0);
        tick_check();
        drive_load("rd5",      1'b1, 2'b00, 2'b00, 1'b1, 4'd5, 16'h7777, 16'h0, 16'h0, 16'h0);
        tick_check();
        drive_load("invalid",  1'b0, 2'b00, 2'b00, 1'b1, 4'd5, 16'h6666, 16'h0, 16'h0, 16'h0);
        tick_check();

        // stall for three cycles, then stall+flush together
        drive_load("ld_rd3",   1'b1, 2'b00, 2'b00, 1'b1, 4'd3, 16'h0011, 16'h0, 16'h0, 16'h0);
        tick_check();
        drive_stall("stall1", 16'hBEEF);
        tick_check();
        drive_stall("stall2", 16'h1357);
        tick_check();
        drive_stall("stall3", 16'hC0DE);
        tick_check();
        drive_stall("flush", 16'h2468);
        flush_w = 1'b1;
        sb.delete();
        e.res = '0; e.rd = '0; e.rw = 1'b0; e.v = 1'b0; e.chk_data = 1'b0; e.tag = "flush";
        sb.push_back(e);
        tick_check();
        drive_load("flush_only", 1'b1, 2'b00, 2'b00, 1'b1, 4'd6, 16'h0AAA, 16'h0, 16'h0, 16'h0);
        flush_w = 1'b1;
        sb.delete();
        e.tag = "flush_only";
        sb.push_back(e);
        tick_check();

        // reset on a live stalled instruction
        drive_load("ld_rd7",   1'b1, 2'b11, 2'b00, 1'b1, 4'd7, 16'h0, 16'h0, 16'h0, 16'h4321);
        tick_check();
        drive_stall("rst_stall", 16'h9999);
        rst = 1'b1;
        sb.delete();
        e.res = '0; e.rd = '0; e.rw = 1'b0; e.v = 1'b0; e.chk_data = 1'b1; e.tag = "rst_stall";
        sb.push_back(e);
        tick_check();

        // post-reset load counts again from zero
        drive_load("post_rst", 1'b1, 2'b10, 2'b00, 1'b1, 4'd8, 16'h0, 16'h0, 16'h00A4, 16'h0);
        tick_check();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
